// File: rtl/mips_shift_arbiter.sv
// mips_shift_arbiter: two-requester round-robin arbiter in front of one shared
// MIPS-style shifter (SLL / SRL / SRA / rotate right) with a single result register.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid / reqN_ready       requester N handshake (ready is combinational)
//   reqN_op                       00 SLL, 01 SRL, 10 SRA, 11 rotate right
//   reqN_amount, reqN_data        shift distance and operand
//   res_valid / res_ready         result register handshake
//   res_data, res_id              shifted result and index of the producing requester
//   grant_cnt0, grant_cnt1        saturating grant counters (only with SHIFT_ARB_STATS_EN)
//
// Build option: define SHIFT_ARB_STATS_EN to add the per-requester grant counters.
module mips_shift_arbiter #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned AMOUNT_WIDTH = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req0_valid,
   output logic                    req0_ready,
   input  logic [1:0]              req0_op,
   input  logic [AMOUNT_WIDTH-1:0] req0_amount,
   input  logic [DATA_WIDTH-1:0]   req0_data,
   input  logic                    req1_valid,
   output logic                    req1_ready,
   input  logic [1:0]              req1_op,
   input  logic [AMOUNT_WIDTH-1:0] req1_amount,
   input  logic [DATA_WIDTH-1:0]   req1_data,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [DATA_WIDTH-1:0]   res_data,
   output logic                    res_id
`ifdef SHIFT_ARB_STATS_EN
   ,
   output logic [15:0]             grant_cnt0,
   output logic [15:0]             grant_cnt1
`endif
);

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROR = 2'b11
   } shift_op_e;

   logic                    res_valid_q, res_valid_d;
   logic [DATA_WIDTH-1:0]   res_data_q,  res_data_d;
   logic                    res_id_q,    res_id_d;
   logic                    prio_q,      prio_d;

   logic                    slot_free;
   logic                    grant0;
   logic                    grant1;
   logic [1:0]              sel_op;
   logic [AMOUNT_WIDTH-1:0] sel_amount;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic [DATA_WIDTH-1:0]   shift_result;
   logic [AMOUNT_WIDTH-1:0] rot_idx;

   // Round-robin arbitration; no grant while in reset or while the result slot is blocked.
   always_comb begin
      slot_free = !res_valid_q || res_ready;
      grant0    = 1'b0;
      grant1    = 1'b0;
      if (rst_n && slot_free) begin
         if (req0_valid && (!req1_valid || !prio_q)) begin
            grant0 = 1'b1;
         end else if (req1_valid) begin
            grant1 = 1'b1;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Operand select for the shared shifter.
   always_comb begin
      sel_op     = grant1 ? req1_op     : req0_op;
      sel_amount = grant1 ? req1_amount : req0_amount;
      sel_data   = grant1 ? req1_data   : req0_data;
   end

   // Shared shifter; rotate uses modulo-DATA_WIDTH indexing so amount 0 is identity.
   always_comb begin
      shift_result = sel_data;
      rot_idx      = '0;
      case (shift_op_e'(sel_op))
         OP_SLL: shift_result = sel_data << sel_amount;
         OP_SRL: shift_result = sel_data >> sel_amount;
         OP_SRA: shift_result = DATA_WIDTH'($signed(sel_data) >>> sel_amount);
         OP_ROR: begin
            for (int i = 0; i < int'(DATA_WIDTH); i++) begin
               rot_idx         = AMOUNT_WIDTH'(i) + sel_amount;
               shift_result[i] = sel_data[rot_idx];
            end
         end
         default: shift_result = sel_data;
      endcase
   end

   // Result register and priority pointer next state.
   always_comb begin
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_id_d    = res_id_q;
      prio_d      = prio_q;
      if (grant0 || grant1) begin
         res_valid_d = 1'b1;
         res_data_d  = shift_result;
         res_id_d    = grant1;
         prio_d      = grant0;   // point at the requester that was not granted
      end else if (res_ready) begin
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_id_q    <= 1'b0;
         prio_q      <= 1'b0;
      end else begin
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_id_q    <= res_id_d;
         prio_q      <= prio_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;

`ifdef SHIFT_ARB_STATS_EN
   localparam int unsigned CNT_WIDTH = 16;

   logic [CNT_WIDTH-1:0] grant_cnt0_q, grant_cnt0_d;
   logic [CNT_WIDTH-1:0] grant_cnt1_q, grant_cnt1_d;

   // Saturating grant counters.
   always_comb begin
      grant_cnt0_d = grant_cnt0_q;
      grant_cnt1_d = grant_cnt1_q;
      if (grant0 && (grant_cnt0_q != '1)) begin
         grant_cnt0_d = grant_cnt0_q + CNT_WIDTH'(1);
      end
      if (grant1 && (grant_cnt1_q != '1)) begin
         grant_cnt1_d = grant_cnt1_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt0_q <= '0;
         grant_cnt1_q <= '0;
      end else begin
         grant_cnt0_q <= grant_cnt0_d;
         grant_cnt1_q <= grant_cnt1_d;
      end
   end

   assign grant_cnt0 = grant_cnt0_q;
   assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule
